// File: rtl/ripple_add_arb_pkg.sv
// Shared definitions for the ripple_add_arb block.
//   state_e      : controller states (IDLE, ADD, DONE)
//   DEF_SLICE_W  : default width of the shared ripple slice
//   DEF_NSLICE   : default number of slices per operand
//   ID_W         : width of the requester id carried with each result
package ripple_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_SLICE_W = 4;
  localparam int DEF_NSLICE  = 4;
  localparam int ID_W        = 1;

endpackage

// File: rtl/ripple_add_arb_if.sv
// Request/response bundle for ripple_add_arb.
//   req0_* / req1_* : two operand requesters (valid/ready, a, b, carry-in)
//   rsp_*           : tagged result channel (valid/ready, sum, carry-out, id)
//   busy            : adder is working on or holding a result
// Modports: master = requester/consumer side, slave = the adder.
interface ripple_add_arb_if
  #(parameter int W = ripple_add_pkg::DEF_SLICE_W * ripple_add_pkg::DEF_NSLICE);
  import ripple_add_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  logic [W-1:0]    req0_a;
  logic [W-1:0]    req0_b;
  logic            req0_ci;

  logic            req1_valid;
  logic            req1_ready;
  logic [W-1:0]    req1_a;
  logic [W-1:0]    req1_b;
  logic            req1_ci;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_sum;
  logic            rsp_co;
  logic [ID_W-1:0] rsp_id;
  logic            busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ci,
    output req1_valid, req1_a, req1_b, req1_ci,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_co, rsp_id, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ci,
    input  req1_valid, req1_a, req1_b, req1_ci,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_co, rsp_id, busy,
    input  rsp_ready
  );

endinterface

// File: rtl/ripple_add_arb_adder.sv
// ripple_adder: plain n-bit ripple-carry adder slice.
//   a, b : n-bit operands
//   ci   : carry-in
//   s    : n-bit sum
//   co   : carry-out of the top bit
module ripple_adder #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         ci,
  output logic [n-1:0] s,
  output logic         co
);

  logic [n:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < n; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[n];
  end

endmodule

// File: rtl/ripple_add_arb.sv
// ripple_add_arb: two-requester wide adder built on one shared ripple slice.
// A round-robin arbiter accepts one operand pair at a time; the sum is then
// built one SLICE_W-bit slice per cycle (LSB first) with the carry held in a
// register between cycles, and returned tagged with the requester id.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ripple_add_arb_if.slave (requests, response, busy)
module ripple_add_arb
  import ripple_add_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int NSLICE  = DEF_NSLICE
) (
  input logic              clk,
  input logic              rst_n,
  ripple_add_arb_if.slave  bus
);

  localparam int W     = SLICE_W * NSLICE;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            last_grant_q, last_grant_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_co_q, rsp_co_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            grant_id;
  logic            idle_ok;
  logic            accept;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic            slice_co;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // rst_n gates the readys so nothing looks acceptable while reset is held.
  assign idle_ok        = rst_n && (state_q == IDLE);
  assign bus.req0_ready = idle_ok && !grant_id && bus.req0_valid;
  assign bus.req1_ready = idle_ok &&  grant_id && bus.req1_valid;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  ripple_adder #(.n(SLICE_W)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_co_d     = rsp_co_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = grant_id ? bus.req1_a  : bus.req0_a;
          b_d          = grant_id ? bus.req1_b  : bus.req0_b;
          carry_d      = grant_id ? bus.req1_ci : bus.req0_ci;
          idx_d        = '0;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          state_d      = ADD;
        end
      end
      ADD: begin
        sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          rsp_co_d    = slice_co;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_co_q     <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_co_q     <= rsp_co_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_co    = rsp_co_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
